serial_word_rx: RTL
===================

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 3; the number of serial bits per word, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit; a frame-start strobe.
REQ-005 SHALL have port w, input, 1 bit; the serial data bit.
REQ-006 SHALL have port w_valid, input, 1 bit; w is sampled only when w_valid is high.
REQ-007 SHALL have port q, output, WIDTH bits; the received parallel word.
REQ-008 SHALL have port q_valid, output, 1 bit; q holds an unconsumed word.
REQ-009 SHALL have port q_ready, input, 1 bit; the consumer accepts q when q_valid and q_ready are both high.
REQ-010 SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.
REQ-011 SHALL have port overrun, output, 1 bit; a one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-012 SHALL implement an FSM with states IDLE and SHIFT, plus PARITY when the parity feature is enabled (REQ-026).
REQ-013 In IDLE: start=1 -> go to SHIFT with bit count=0; w_valid SHALL be ignored.
REQ-014 In SHIFT: each cycle with w_valid=1 -> w shifts into the shift register MSB, existing bits shift right by one, count increments.
REQ-015 Bits SHALL arrive LSB-first, so after WIDTH shifts the first-received bit sits in bit 0.
REQ-016 In SHIFT with w_valid=0 -> no shift and no count change; there is no timeout.
REQ-017 When the WIDTH-th bit is sampled (no parity), the completed word SHALL load into q with q_valid=1 at that same edge, and the state returns to IDLE.
REQ-018 Latency: q_valid SHALL be visible in the cycle after the last bit's sampling edge.
REQ-019 start=1 while in SHIFT or PARITY -> discard the partial word, set count=0, remain in or re-enter SHIFT.
REQ-020 q_valid=1 and q_ready=1 with no word completing -> q_valid cleared next edge; q is held unchanged.
REQ-021 A word completes while q_valid=1 and q_ready=0 -> q is overwritten, q_valid stays 1, and overrun pulses for one cycle.
REQ-022 A word completes while q_valid=1 and q_ready=1 -> the new word loads, q_valid stays 1, and no overrun.
REQ-023 The output register SHALL be independent of the shift register, so a new frame may start while q_valid=1.

Reset
REQ-024 reset=0 sampled at a clk edge -> state IDLE, count 0, shift register 0.
REQ-025 Reset values of outputs: q=0, q_valid=0, busy=0, overrun=0, and perr=0 when present; reset mid-frame or mid-hold discards all data.

Configuration
REQ-026 Macro SERIAL_RX_PARITY_EN defined -> after the WIDTH-th bit, go to PARITY; the next w_valid=1 bit is an even-parity bit over the word.
REQ-027 With SERIAL_RX_PARITY_EN: parity correct -> deliver the word per REQ-017/REQ-021/REQ-022; parity wrong -> discard the word, leave q and q_valid unchanged, pulse output perr (1 bit) for one cycle; both cases return to IDLE.
REQ-028 Macro SERIAL_RX_PARITY_EN undefined -> no PARITY state and no perr port.

Structure
REQ-029 Shared package serial_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and constant SERIAL_WIDTH_DEFAULT=3.
REQ-030 The bit counter SHALL be a sub-module bit_counter (clear, enable, terminal-count output at WIDTH-1); all other logic stays in serial_word_rx.

Verification
REQ-031 WIDTH=3, start, then bits 1,1,0 on consecutive w_valid cycles -> q=3'b011, q_valid=1 one cycle after the 3rd bit, busy=0.
REQ-032 Bits 1,0 with w_valid gaps, then 1 -> q=3'b101; the gaps add no shifts.
REQ-033 Word 3'b011 held with q_ready=0, then second frame 0,0,1 -> q=3'b100 and overrun pulses once; repeat with q_ready=1 at completion -> no pulse.
REQ-034 Start, bits 1,1, then start again, then bits 0,1,0 -> q=3'b010.
REQ-035 reset=0 after two bits, then a full frame 1,0,0 -> q=3'b001 with no stale bits.
REQ-036 SERIAL_RX_PARITY_EN: bits 1,1,0 with parity bit 0 -> q=3'b011; same bits with parity bit 1 -> perr pulses and q_valid stays 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } serial_state_t;

  localparam int SERIAL_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/bit_counter.sv
// Received-bit counter: clears to zero, advances on enable, flags the last bit of a word.
module bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      // Wrap on the final bit so the next frame starts from zero
      count_reg <= terminal ? '0 : count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == LAST);

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial-to-parallel word receiver with a held output register.
// Optional even-parity check is compiled in when SERIAL_RX_PARITY_EN is defined.
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             w,
  input  logic             w_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
`ifdef SERIAL_RX_PARITY_EN
  output logic             perr,
`endif
  output logic             overrun
);

  serial_state_t    state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic             overrun_reg, overrun_next;
  logic             perr_reg, perr_next;

  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_terminal;
  logic             word_done;
  logic [WIDTH-1:0] word_value;
  logic [WIDTH-1:0] shifted;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .terminal(cnt_terminal)
  );

  // New bit enters at the MSB so the first-received bit ends up in bit 0
  assign shifted = {w, shift_reg[WIDTH-1:1]};

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    q_next       = q_reg;
    q_valid_next = q_valid_reg & ~q_ready;
    overrun_next = 1'b0;
    perr_next    = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    word_done    = 1'b0;
    word_value   = '0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          shift_next = '0;
          cnt_clear  = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          shift_next = '0;
          cnt_clear  = 1'b1;
        end else if (w_valid) begin
          shift_next = shifted;
          cnt_en     = 1'b1;
          if (cnt_terminal) begin
`ifdef SERIAL_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            word_done  = 1'b1;
            word_value = shifted;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (start) begin
          state_next = SHIFT;
          shift_next = '0;
          cnt_clear  = 1'b1;
        end else if (w_valid) begin
          state_next = IDLE;
          // Even parity: data bits plus parity bit must XOR to zero
          if ((^shift_reg ^ w) == 1'b0) begin
            word_done  = 1'b1;
            word_value = shift_reg;
          end else begin
            perr_next = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase

    if (word_done) begin
      q_next       = word_value;
      q_valid_next = 1'b1;
      overrun_next = q_valid_reg & ~q_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
      overrun_reg <= overrun_next;
      perr_reg    <= perr_next;
    end
  end

  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign overrun = overrun_reg;
  assign busy    = (state_reg != IDLE);

`ifdef SERIAL_RX_PARITY_EN
  assign perr = perr_reg;
`else
  // perr_reg is constant zero without the parity feature; it is kept so both builds share one datapath
  logic unused_perr;
  assign unused_perr = perr_reg;
`endif

endmodule
